uart_alu_intf_multi: RTL and testbench

Parametrised UART-to-ALU interface between the UART receiver/transmitter pair and the ALU on the board. Collects operand A, operand B and an opcode from a byte stream, with operands DATA_W bits wide and sent as DATA_W/8 bytes each. Presents them to the combinational ALU, captures the result, and returns it over the transmitter handshake as DATA_W/8 bytes. Generalises the fixed 8-bit, three-byte exchange (A, B, opcode, one result byte) to multi-byte operands, with drop reporting and an optional frame timeout.

---
 rtl/uart_intf_pkg.sv | 25 ++
 rtl/uart_byte_assembler.sv | 29 ++
 rtl/uart_alu_intf_multi.sv | 146 ++++++++++++++
 tb/tb_uart_alu_intf_multi.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_intf_pkg.sv
// rtl/uart_intf_pkg.sv - shared types and sizing helpers for the UART-to-ALU interface.
package uart_intf_pkg;

  typedef enum logic [2:0] {
    RX_A,
    RX_B,
    RX_OP,
    EXEC,
    TX_LOAD,
    TX_WAIT
  } state_t;

  localparam int BYTE_W           = 8;
  localparam int OPCODE_W_DEFAULT = 6;

  function automatic int bytes_of(input int width);
    return width / BYTE_W;
  endfunction

  // Byte index width; a single-byte field still gets a 1-bit index.
  function automatic int idx_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/uart_byte_assembler.sv
// rtl/uart_byte_assembler.sv - little-endian operand register written one byte at a time.
module uart_byte_assembler
  import uart_intf_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                                 clock,
  input  logic                                 clear,
  input  logic                                 load,
  input  logic [idx_width(bytes_of(DATA_W))-1:0] index,
  input  logic [BYTE_W-1:0]                    byte_in,
  output logic [DATA_W-1:0]                    value
);

  localparam int BYTES = bytes_of(DATA_W);

  logic [BYTES-1:0][BYTE_W-1:0] bytes_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      bytes_q <= '0;
    end else if (load) begin
      bytes_q[index] <= byte_in;
    end
  end

  assign value = bytes_q;

endmodule

// File: rtl/uart_alu_intf_multi.sv
// rtl/uart_alu_intf_multi.sv - collects A, B, opcode from UART bytes, returns the ALU result bytes.
// Define UART_INTF_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle clocks.
module uart_alu_intf_multi
  import uart_intf_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int OPCODE_W       = OPCODE_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done,
  input  logic [7:0]          i_rx_data,
  output logic                o_tx_start,
  output logic [7:0]          o_tx_data,
  input  logic                i_tx_done,
  output logic [DATA_W-1:0]   o_op_a,
  output logic [DATA_W-1:0]   o_op_b,
  output logic [OPCODE_W-1:0] o_opcode,
  input  logic [DATA_W-1:0]   i_result,
  output logic                o_busy,
  output logic                o_rx_drop,
  output logic                o_timeout
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int IDX_W = idx_width(BYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

  state_t                       state, state_next;
  logic [IDX_W-1:0]             rx_cnt, tx_idx, tx_idx_next;
  logic [BYTES-1:0][BYTE_W-1:0] result_q;
  logic                         rx_last, load_a, load_b, frame_open, timeout_hit;

  assign rx_last     = (rx_cnt == LAST);
  assign tx_idx_next = tx_idx + 1'b1;
  assign load_a      = i_rx_done && (state == RX_A);
  assign load_b      = i_rx_done && (state == RX_B);
  assign frame_open  = ((state == RX_A) && (rx_cnt != '0)) || (state == RX_B) || (state == RX_OP);

`ifdef UART_INTF_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_rx_done || !frame_open) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // A byte arriving on the final idle cycle rescues the frame.
  assign timeout_hit = frame_open && !i_rx_done && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  uart_byte_assembler #(.DATA_W(DATA_W)) u_asm_a (
    .clock  (i_clock),
    .clear  (i_reset),
    .load   (load_a),
    .index  (rx_cnt),
    .byte_in(i_rx_data),
    .value  (o_op_a)
  );

  uart_byte_assembler #(.DATA_W(DATA_W)) u_asm_b (
    .clock  (i_clock),
    .clear  (i_reset),
    .load   (load_b),
    .index  (rx_cnt),
    .byte_in(i_rx_data),
    .value  (o_op_b)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= RX_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_A:    if (i_rx_done && rx_last) state_next = RX_B;
      RX_B:    if (i_rx_done && rx_last) state_next = RX_OP;
      RX_OP:   if (i_rx_done) state_next = EXEC;
      EXEC:    state_next = TX_LOAD;
      TX_LOAD: state_next = TX_WAIT;
      TX_WAIT: if (i_tx_done) state_next = (tx_idx == LAST) ? RX_A : TX_LOAD;
      default: state_next = RX_A;
    endcase
    if (timeout_hit) begin
      state_next = RX_A;
    end
  end

  // o_tx_data is loaded on the edge entering TX_LOAD so it is valid alongside o_tx_start.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_cnt    <= '0;
      tx_idx    <= '0;
      result_q  <= '0;
      o_opcode  <= '0;
      o_tx_data <= '0;
    end else begin
      if (timeout_hit) begin
        rx_cnt <= '0;
      end else if (load_a || load_b) begin
        rx_cnt <= rx_last ? '0 : rx_cnt + 1'b1;
      end
      if ((state == RX_OP) && i_rx_done) begin
        o_opcode <= i_rx_data[OPCODE_W-1:0];
      end
      if (state == EXEC) begin
        result_q  <= i_result;
        tx_idx    <= '0;
        o_tx_data <= i_result[7:0];
      end
      if ((state == TX_WAIT) && i_tx_done) begin
        tx_idx <= tx_idx_next;
        if (tx_idx != LAST) begin
          o_tx_data <= result_q[tx_idx_next];
        end
      end
    end
  end

  always_comb begin
    o_tx_start = 1'b0;
    o_rx_drop  = 1'b0;
    o_timeout  = 1'b0;
    o_busy     = !((state == RX_A) && (rx_cnt == '0));
    if (!i_reset) begin
      o_tx_start = (state == TX_LOAD);
      o_rx_drop  = i_rx_done && ((state == EXEC) || (state == TX_LOAD) || (state == TX_WAIT));
      o_timeout  = timeout_hit;
    end
  end

endmodule

// File: tb/tb_uart_alu_intf_multi.sv
// tb/tb_uart_alu_intf_multi.sv - directed and randomized frames against a byte-level reference model.
module tb_uart_alu_intf_multi;

  localparam int DATA_W   = 16;
  localparam int BYTES    = DATA_W / 8;
  localparam int OPCODE_W = 6;

  logic                clk = 1'b0;
  logic                reset, rx_done, tx_done;
  logic [7:0]          rx_data;
  logic                tx_start, busy, rx_drop, timeout;
  logic [7:0]          tx_data;
  logic [DATA_W-1:0]   op_a, op_b, result;
  logic [OPCODE_W-1:0] opcode;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_ref(input logic [DATA_W-1:0] a, b,
                                                input logic [OPCODE_W-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a;
    endcase
  endfunction

  assign result = alu_ref(op_a, op_b, opcode);

  uart_alu_intf_multi #(.DATA_W(DATA_W), .OPCODE_W(OPCODE_W), .TIMEOUT_CYCLES(100)) dut (
    .i_clock   (clk),
    .i_reset   (reset),
    .i_rx_done (rx_done),
    .i_rx_data (rx_data),
    .o_tx_start(tx_start),
    .o_tx_data (tx_data),
    .i_tx_done (tx_done),
    .o_op_a    (op_a),
    .o_op_b    (op_b),
    .o_opcode  (opcode),
    .i_result  (result),
    .o_busy    (busy),
    .o_rx_drop (rx_drop),
    .o_timeout (timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves at the following negedge with rx_done low.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    #1;
    check("rx_drop_on_store", rx_drop, 1'b0);
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // mode 0: plain; 1: stray byte in TX_WAIT; 2: byte together with first tx_done.
  task automatic run_frame(input logic [DATA_W-1:0] a, b, input logic [7:0] op, input int mode);
    logic [DATA_W-1:0] res;
    logic [7:0]        q[$];
    int                d;
    res = alu_ref(a, b, op[OPCODE_W-1:0]);
    for (int i = 0; i < BYTES; i++) q.push_back(res[8*i +: 8]);
    for (int i = 0; i < BYTES; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < BYTES; i++) send_byte(b[8*i +: 8]);
    send_byte(op);
    check("start_in_exec", tx_start, 1'b0);
    check("busy_in_exec", busy, 1'b1);
    @(negedge clk);
    check("op_a", op_a, a);
    check("op_b", op_b, b);
    check("opcode", opcode, op[OPCODE_W-1:0]);
    for (int k = 0; k < BYTES; k++) begin
      check("tx_start", tx_start, 1'b1);
      check("tx_data", tx_data, q[k]);
      @(negedge clk);
      d = $urandom_range(0, 3);
      repeat (d) begin
        check("start_while_wait", tx_start, 1'b0);
        check("tx_data_held", tx_data, q[k]);
        @(negedge clk);
      end
      if (mode == 1 && k == 0) begin
        rx_done = 1'b1;
        rx_data = 8'($urandom);
        #1;
        check("drop_in_tx_wait", rx_drop, 1'b1);
        @(negedge clk);
        rx_done = 1'b0;
        #1;
        check("drop_one_cycle", rx_drop, 1'b0);
      end
      tx_done = 1'b1;
      if (mode == 2 && k == 0) begin
        rx_done = 1'b1;
        rx_data = 8'($urandom);
        #1;
        check("drop_with_tx_done", rx_drop, 1'b1);
      end
      @(negedge clk);
      tx_done = 1'b0;
      rx_done = 1'b0;
    end
    check("idle_after_frame", busy, 1'b0);
    check("no_start_after_frame", tx_start, 1'b0);
    check("op_a_held", op_a, a);
    check("op_b_held", op_b, b);
  endtask

  logic [7:0] ops[7] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'hE2};
  int first_to;

  initial begin
    reset   = 1'b1;
    rx_done = 1'b0;
    tx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_op_a", op_a, '0);
    check("reset_op_b", op_b, '0);
    check("reset_opcode", opcode, '0);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_tx_start", tx_start, 1'b0);
    check("reset_rx_drop", rx_drop, 1'b0);
    check("reset_timeout", timeout, 1'b0);
    @(negedge clk);

    run_frame(16'h1234, 16'h0001, 8'h20, 0);

    // Reset mid-frame: A fully received, then reset.
    send_byte(8'h34);
    check("busy_partial", busy, 1'b1);
    send_byte(8'h12);
    check("partial_op_a", op_a, 16'h1234);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_op_a", op_a, '0);
    check("midreset_busy", busy, 1'b0);
    @(negedge clk);
    run_frame(16'hBEEF, 16'h0101, 8'h22, 0);

    run_frame(16'h00FF, 16'h0F0F, 8'h26, 1);
    run_frame(16'h8001, 16'h7FFF, 8'h20, 2);

`ifdef UART_INTF_TIMEOUT_EN
    send_byte(8'h5A);
    first_to = -1;
    for (int k = 1; k <= 150; k++) begin
      if (timeout === 1'b1 && first_to < 0) first_to = k;
      @(negedge clk);
    end
    check("timeout_cycle", first_to, 100);
    check("timeout_busy", busy, 1'b0);
    check("timeout_keeps_a", op_a[7:0], 8'h5A);
    run_frame(16'h0102, 16'h0304, 8'h25, 0);
`else
    send_byte(8'h5A);
    first_to = 0;
    repeat (150) begin
      if (timeout !== 1'b0) first_to++;
      @(negedge clk);
    end
    check("no_timeout_pulses", first_to, 0);
    check("partial_waits", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif

    for (int n = 0; n < 8; n++) begin
      run_frame(DATA_W'($urandom), DATA_W'($urandom), ops[$urandom_range(0, 6)],
                int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
